// File: rtl/ahb_master_ctrl.sv
// AHB-Lite burst master: turns one local command (address, direction, beat
// count) into a SINGLE/INCR word burst, inserting BUSY for write-data gaps,
// stretching on hready and cancelling the burst on an ERROR response.
module ahb_master_ctrl #(
   parameter int MAX_LEN_W = 4,
   parameter int ADDR_INC  = 4
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [31:0]          cmd_addr,
   input  logic [MAX_LEN_W-1:0] cmd_len,
   input  logic                 wd_valid,
   output logic                 wd_ready,
   input  logic [31:0]          wd_data,
   input  logic                 hready,
   input  logic [1:0]           hresp,
   input  logic [31:0]          hrdata,
   output logic [31:0]          haddr,
   output logic [1:0]           htrans,
   output logic                 hwrite,
   output logic [31:0]          hwdata,
   output logic                 rd_valid,
   output logic [31:0]          rd_data,
   output logic                 rd_last,
   output logic                 done,
   output logic                 err
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ADDR      = 2'd1,
      S_LAST_DATA = 2'd2,
      S_ERR2      = 2'd3
   } state_t;

   localparam logic [1:0] HT_IDLE    = 2'b00;
   localparam logic [1:0] HT_BUSY    = 2'b01;
   localparam logic [1:0] HT_NONSEQ  = 2'b10;
   localparam logic [1:0] HT_SEQ     = 2'b11;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   localparam logic [31:0]          ADDR_STEP = 32'(ADDR_INC);
   localparam logic [MAX_LEN_W-1:0] LEN_ONE   = MAX_LEN_W'(1);

   state_t                 state_q, state_d;
   logic [31:0]            addr_q, addr_d;         // address of the beat being issued
   logic [MAX_LEN_W-1:0]   left_q, left_d;         // beats remaining after the current one
   logic                   first_q, first_d;       // current beat is beat 0 (NONSEQ)
   logic                   wr_q, wr_d;
   logic [31:0]            hwdata_q, hwdata_d;
   logic                   dph_q, dph_d;           // a data phase is outstanding
   logic                   dph_last_q, dph_last_d; // outstanding data phase is the final beat
   logic                   hold_q, hold_d;         // previous address phase saw hready=0
   logic [1:0]             hold_trans_q, hold_trans_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic [1:0]             htrans_c;
   logic                   wd_ready_c;
   logic                   addr_acc;
   logic                   data_ok;
   logic                   data_err;

   assign data_ok  = dph_q & hready & (hresp == RESP_OKAY);
   assign data_err = dph_q & (hresp == RESP_ERROR);

   // Next-state, bus transfer type and pipeline bookkeeping
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      left_d       = left_q;
      first_d      = first_q;
      wr_d         = wr_q;
      hwdata_d     = hwdata_q;
      dph_d        = dph_q;
      dph_last_d   = dph_last_q;
      hold_d       = 1'b0;
      hold_trans_d = hold_trans_q;
      cmd_ready_d  = cmd_ready_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      htrans_c     = HT_IDLE;
      wd_ready_c   = 1'b0;
      addr_acc     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               addr_d      = cmd_addr;
               wr_d        = cmd_write;
               left_d      = cmd_len;
               first_d     = 1'b1;
               cmd_ready_d = 1'b0;
               state_d     = S_ADDR;
            end
         end
         S_ADDR: begin
            // A transfer shown during a wait state is frozen until hready;
            // write data is expected to stay valid once offered.
            if (hold_q) begin
               htrans_c = hold_trans_q;
            end else if (wr_q && !wd_valid) begin
               htrans_c = first_q ? HT_IDLE : HT_BUSY;
            end else begin
               htrans_c = first_q ? HT_NONSEQ : HT_SEQ;
            end
            // First ERROR cycle: withdraw the pending address immediately.
            if (data_err) begin
               htrans_c = HT_IDLE;
            end
            addr_acc = hready && htrans_c[1];
         end
         S_ERR2: begin
            if (hready) begin
               done_d      = 1'b1;
               err_d       = 1'b1;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: ;
      endcase

      if (state_q == S_ADDR || state_q == S_LAST_DATA) begin
         if (data_err) begin
            dph_d = 1'b0;
            if (hready) begin
               done_d      = 1'b1;
               err_d       = 1'b1;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end else begin
               state_d = S_ERR2;
            end
         end else begin
            if (data_ok) begin
               dph_d = 1'b0;
               if (state_q == S_LAST_DATA) begin
                  done_d      = 1'b1;
                  cmd_ready_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
            if (addr_acc) begin
               dph_d      = 1'b1;
               dph_last_d = (left_q == '0);
               if (wr_q) begin
                  wd_ready_c = 1'b1;
                  hwdata_d   = wd_data;
               end
               if (left_q == '0) begin
                  state_d = S_LAST_DATA;
               end else begin
                  addr_d  = addr_q + ADDR_STEP;
                  left_d  = left_q - LEN_ONE;
                  first_d = 1'b0;
               end
            end else if (state_q == S_ADDR && !hready) begin
               hold_d       = 1'b1;
               hold_trans_d = htrans_c;
            end
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         left_q       <= '0;
         first_q      <= 1'b0;
         wr_q         <= 1'b0;
         hwdata_q     <= '0;
         dph_q        <= 1'b0;
         dph_last_q   <= 1'b0;
         hold_q       <= 1'b0;
         hold_trans_q <= HT_IDLE;
         cmd_ready_q  <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         left_q       <= left_d;
         first_q      <= first_d;
         wr_q         <= wr_d;
         hwdata_q     <= hwdata_d;
         dph_q        <= dph_d;
         dph_last_q   <= dph_last_d;
         hold_q       <= hold_d;
         hold_trans_q <= hold_trans_d;
         cmd_ready_q  <= cmd_ready_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign htrans    = htrans_c;
   assign haddr     = addr_q;
   assign hwrite    = wr_q;
   assign hwdata    = hwdata_q;
   assign cmd_ready = cmd_ready_q;
   assign wd_ready  = wd_ready_c;
   assign rd_valid  = data_ok & ~wr_q;
   assign rd_data   = hrdata;
   assign rd_last   = data_ok & ~wr_q & dph_last_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Directed bench for ahb_master_ctrl: cycle-by-cycle expected bus values.
module tb_ahb_master_ctrl;

   logic        hclk;
   logic        hreset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [3:0]  cmd_len;
   logic        wd_valid;
   logic        wd_ready;
   logic [31:0] wd_data;
   logic        hready;
   logic [1:0]  hresp;
   logic [31:0] hrdata;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [31:0] hwdata;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;
   logic        done;
   logic        err;

   int checks;
   int failures;
   int pops;
   int rds;

   localparam logic [31:0] T_IDLE   = 32'd0;
   localparam logic [31:0] T_BUSY   = 32'd1;
   localparam logic [31:0] T_NONSEQ = 32'd2;
   localparam logic [31:0] T_SEQ    = 32'd3;

   ahb_master_ctrl #(.MAX_LEN_W(4), .ADDR_INC(4)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .hready    (hready),
      .hresp     (hresp),
      .hrdata    (hrdata),
      .haddr     (haddr),
      .htrans    (htrans),
      .hwrite    (hwrite),
      .hwdata    (hwdata),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .done      (done),
      .err       (err)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Move to just after the next rising edge, where inputs are driven.
   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   // Let combinational outputs settle, well before the falling edge.
   task automatic smp();
      #3;
      if (wd_ready) pops++;
      if (rd_valid) rds++;
   endtask

   task automatic bus(input string tag, input logic [31:0] t, input logic [31:0] a);
      check_eq({tag, ".htrans"}, 32'(htrans), t);
      check_eq({tag, ".haddr"}, haddr, a);
   endtask

   task automatic cmd(input logic w, input logic [31:0] a, input logic [3:0] l);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_len   = l;
   endtask

   initial begin
      checks = 0; failures = 0; pops = 0; rds = 0;
      hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_len = '0; wd_valid = 1'b0; wd_data = '0; hready = 1'b1;
      hresp = 2'b00; hrdata = '0;

      // Reset state
      cyc(); cyc(); smp();
      check_eq("rst.htrans", 32'(htrans), T_IDLE);
      check_eq("rst.haddr", haddr, 32'h0);
      check_eq("rst.hwrite", 32'(hwrite), 32'd0);
      check_eq("rst.hwdata", hwdata, 32'h0);
      check_eq("rst.cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("rst.wd_ready", 32'(wd_ready), 32'd0);
      check_eq("rst.rd_valid", 32'(rd_valid), 32'd0);
      check_eq("rst.rd_last", 32'(rd_last), 32'd0);
      check_eq("rst.done", 32'(done), 32'd0);
      check_eq("rst.err", 32'(err), 32'd0);
      cyc(); hreset = 1'b0; smp();
      check_eq("rel.cmd_ready0", 32'(cmd_ready), 32'd0);

      // Single write
      cyc(); cmd(1'b1, 32'h8000_0010, 4'd0); wd_valid = 1'b1; wd_data = 32'hDEAD_BEEF; smp();
      check_eq("t1.cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("t1.idle", 32'(htrans), T_IDLE);
      cyc(); cmd_valid = 1'b0; smp();
      bus("t1.b0", T_NONSEQ, 32'h8000_0010);
      check_eq("t1.hwrite", 32'(hwrite), 32'd1);
      check_eq("t1.wd_ready", 32'(wd_ready), 32'd1);
      check_eq("t1.busy_rdy", 32'(cmd_ready), 32'd0);
      cyc(); wd_valid = 1'b0; smp();
      check_eq("t1.ld.htrans", 32'(htrans), T_IDLE);
      check_eq("t1.hwdata", hwdata, 32'hDEAD_BEEF);
      check_eq("t1.ld.done", 32'(done), 32'd0);
      cyc(); smp();
      check_eq("t1.done", 32'(done), 32'd1);
      check_eq("t1.err", 32'(err), 32'd0);
      check_eq("t1.cmd_ready", 32'(cmd_ready), 32'd1);

      // 4-beat write with a write-data gap before beat 2
      pops = 0;
      cyc(); cmd(1'b1, 32'h0000_0000, 4'd3); smp();
      cyc(); cmd_valid = 1'b0; wd_valid = 1'b1; wd_data = 32'h1111_1111; smp();
      bus("t2.b0", T_NONSEQ, 32'h0);
      check_eq("t2.b0.wd_ready", 32'(wd_ready), 32'd1);
      cyc(); wd_data = 32'h2222_2222; smp();
      bus("t2.b1", T_SEQ, 32'h4);
      check_eq("t2.b1.hwdata", hwdata, 32'h1111_1111);
      cyc(); wd_valid = 1'b0; smp();
      bus("t2.busy", T_BUSY, 32'h8);
      check_eq("t2.busy.wd_ready", 32'(wd_ready), 32'd0);
      check_eq("t2.busy.hwdata", hwdata, 32'h2222_2222);
      cyc(); wd_valid = 1'b1; wd_data = 32'h3333_3333; smp();
      bus("t2.b2", T_SEQ, 32'h8);
      check_eq("t2.b2.hwdata", hwdata, 32'h2222_2222);
      cyc(); wd_data = 32'h4444_4444; smp();
      bus("t2.b3", T_SEQ, 32'hC);
      check_eq("t2.b3.hwdata", hwdata, 32'h3333_3333);
      cyc(); wd_valid = 1'b0; smp();
      check_eq("t2.ld.htrans", 32'(htrans), T_IDLE);
      check_eq("t2.ld.hwdata", hwdata, 32'h4444_4444);
      check_eq("t2.ld.done", 32'(done), 32'd0);
      cyc(); smp();
      check_eq("t2.done", 32'(done), 32'd1);
      check_eq("t2.err", 32'(err), 32'd0);
      check_eq("t2.pops", 32'(pops), 32'd4);

      // 3-beat read with two wait states on beat 1; busy cmd_valid ignored
      rds = 0;
      cyc(); cmd(1'b0, 32'h8400_0000, 4'd2); smp();
      cyc(); cmd_valid = 1'b0; smp();
      bus("t3.b0", T_NONSEQ, 32'h8400_0000);
      check_eq("t3.hwrite", 32'(hwrite), 32'd0);
      check_eq("t3.b0.rd_valid", 32'(rd_valid), 32'd0);
      cyc(); cmd(1'b1, 32'h1234_0000, 4'd5); hrdata = 32'hA0A0_0000; smp();
      bus("t3.b1", T_SEQ, 32'h8400_0004);
      check_eq("t3.d0.rd_valid", 32'(rd_valid), 32'd1);
      check_eq("t3.d0.rd_data", rd_data, 32'hA0A0_0000);
      check_eq("t3.d0.rd_last", 32'(rd_last), 32'd0);
      check_eq("t3.ignore", 32'(cmd_ready), 32'd0);
      cyc(); hready = 1'b0; hrdata = 32'h0; smp();
      bus("t3.w1", T_SEQ, 32'h8400_0008);
      check_eq("t3.w1.rd_valid", 32'(rd_valid), 32'd0);
      cyc(); cmd_valid = 1'b0; smp();
      bus("t3.w2", T_SEQ, 32'h8400_0008);
      check_eq("t3.w2.rd_valid", 32'(rd_valid), 32'd0);
      cyc(); hready = 1'b1; hrdata = 32'hA1A1_0001; smp();
      bus("t3.b2", T_SEQ, 32'h8400_0008);
      check_eq("t3.d1.rd_data", rd_data, 32'hA1A1_0001);
      check_eq("t3.d1.rd_last", 32'(rd_last), 32'd0);
      cyc(); hrdata = 32'hA2A2_0002; smp();
      check_eq("t3.ld.htrans", 32'(htrans), T_IDLE);
      check_eq("t3.d2.rd_data", rd_data, 32'hA2A2_0002);
      check_eq("t3.d2.rd_last", 32'(rd_last), 32'd1);
      check_eq("t3.d2.done", 32'(done), 32'd0);
      cyc(); smp();
      check_eq("t3.done", 32'(done), 32'd1);
      check_eq("t3.err", 32'(err), 32'd0);
      check_eq("t3.rds", 32'(rds), 32'd3);

      // ERROR on beat 1 of a 4-beat read
      rds = 0;
      cyc(); cmd(1'b0, 32'h0000_0100, 4'd3); smp();
      cyc(); cmd_valid = 1'b0; smp();
      bus("t4.b0", T_NONSEQ, 32'h100);
      cyc(); hrdata = 32'hB0B0_B0B0; smp();
      bus("t4.b1", T_SEQ, 32'h104);
      check_eq("t4.d0.rd_data", rd_data, 32'hB0B0_B0B0);
      cyc(); hready = 1'b0; hresp = 2'b01; smp();
      check_eq("t4.e1.htrans", 32'(htrans), T_IDLE);
      check_eq("t4.e1.rd_valid", 32'(rd_valid), 32'd0);
      cyc(); hready = 1'b1; smp();
      check_eq("t4.e2.htrans", 32'(htrans), T_IDLE);
      check_eq("t4.e2.rd_valid", 32'(rd_valid), 32'd0);
      check_eq("t4.e2.done", 32'(done), 32'd0);
      cyc(); hresp = 2'b00; smp();
      check_eq("t4.done", 32'(done), 32'd1);
      check_eq("t4.err", 32'(err), 32'd1);
      check_eq("t4.htrans", 32'(htrans), T_IDLE);
      check_eq("t4.cmd_ready", 32'(cmd_ready), 32'd1);
      cyc(); smp();
      check_eq("t4.after.htrans", 32'(htrans), T_IDLE);
      check_eq("t4.after.done", 32'(done), 32'd0);
      check_eq("t4.rds", 32'(rds), 32'd1);

      // Reset during beat 2 of an 8-beat write, then a clean restart
      cyc(); cmd(1'b1, 32'h0000_0200, 4'd7); wd_valid = 1'b1; wd_data = 32'h50; smp();
      cyc(); cmd_valid = 1'b0; smp();
      bus("t5.b0", T_NONSEQ, 32'h200);
      cyc(); wd_data = 32'h51; smp();
      bus("t5.b1", T_SEQ, 32'h204);
      cyc(); wd_data = 32'h52; hreset = 1'b1; smp();
      bus("t5.b2", T_SEQ, 32'h208);
      cyc(); hreset = 1'b0; smp();
      bus("t5.rst", T_IDLE, 32'h0);
      check_eq("t5.rst.hwrite", 32'(hwrite), 32'd0);
      check_eq("t5.rst.hwdata", hwdata, 32'h0);
      check_eq("t5.rst.cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("t5.rst.wd_ready", 32'(wd_ready), 32'd0);
      check_eq("t5.rst.done", 32'(done), 32'd0);
      cyc(); cmd(1'b1, 32'h0000_0300, 4'd0); wd_data = 32'hCAFE_F00D; smp();
      check_eq("t5.rel.cmd_ready", 32'(cmd_ready), 32'd1);
      check_eq("t5.rel.done", 32'(done), 32'd0);
      check_eq("t5.rel.htrans", 32'(htrans), T_IDLE);
      cyc(); cmd_valid = 1'b0; smp();
      bus("t5.new", T_NONSEQ, 32'h300);
      check_eq("t5.new.wd_ready", 32'(wd_ready), 32'd1);
      cyc(); wd_valid = 1'b0; smp();
      check_eq("t5.new.hwdata", hwdata, 32'hCAFE_F00D);
      cyc(); smp();
      check_eq("t5.done", 32'(done), 32'd1);
      check_eq("t5.err", 32'(err), 32'd0);

      // Address wrap at the top of the 32-bit space
      cyc(); cmd(1'b0, 32'hFFFF_FFF8, 4'd2); smp();
      cyc(); cmd_valid = 1'b0; smp();
      bus("t6.b0", T_NONSEQ, 32'hFFFF_FFF8);
      cyc(); hrdata = 32'hC0C0_C0C0; smp();
      bus("t6.b1", T_SEQ, 32'hFFFF_FFFC);
      check_eq("t6.d0.rd_data", rd_data, 32'hC0C0_C0C0);
      cyc(); hrdata = 32'hC1C1_C1C1; smp();
      bus("t6.b2", T_SEQ, 32'h0000_0000);
      check_eq("t6.d1.rd_valid", 32'(rd_valid), 32'd1);
      cyc(); hrdata = 32'hC2C2_C2C2; smp();
      check_eq("t6.d2.rd_last", 32'(rd_last), 32'd1);
      check_eq("t6.d2.rd_data", rd_data, 32'hC2C2_C2C2);
      cyc(); smp();
      check_eq("t6.done", 32'(done), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
